// File: rtl/xgs_status_collector.sv
// Per-channel saturating error/warning counters with sticky flags, an atomic shadow
// bank read through a one-cycle handshake, and a registered threshold interrupt.
module xgs_status_collector #(
    parameter int  NB_CHANNELS = 4,
    parameter int  CNT_WIDTH   = 16,
    localparam int SEL_WIDTH   = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   enable,
    input  logic [NB_CHANNELS-1:0] evt_error,
    input  logic [NB_CHANNELS-1:0] evt_warning,
    input  logic [CNT_WIDTH-1:0]   err_threshold,
    input  logic [NB_CHANNELS-1:0] irq_mask,
    input  logic                   snapshot,
    input  logic                   clr_sel,
    input  logic                   clr_all,
    input  logic                   rd_req,
    input  logic [SEL_WIDTH-1:0]   rd_sel,
    output logic                   rd_ack,
    output logic [CNT_WIDTH-1:0]   rd_error_cnt,
    output logic [CNT_WIDTH-1:0]   rd_warning_cnt,
    output logic [1:0]             rd_flags,
    output logic                   error_any,
    output logic                   irq
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0]   err_cnt_q  [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   err_cnt_d  [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   warn_cnt_q [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   warn_cnt_d [NB_CHANNELS];
    logic [NB_CHANNELS-1:0] err_flag_q, err_flag_d;
    logic [NB_CHANNELS-1:0] warn_flag_q, warn_flag_d;

    logic [CNT_WIDTH-1:0]   sh_err_cnt_q  [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   sh_err_cnt_d  [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   sh_warn_cnt_q [NB_CHANNELS];
    logic [CNT_WIDTH-1:0]   sh_warn_cnt_d [NB_CHANNELS];
    logic [NB_CHANNELS-1:0] sh_err_flag_q, sh_err_flag_d;
    logic [NB_CHANNELS-1:0] sh_warn_flag_q, sh_warn_flag_d;

    logic                 rd_ack_q, rd_ack_d;
    logic [CNT_WIDTH-1:0] rd_error_cnt_q, rd_error_cnt_d;
    logic [CNT_WIDTH-1:0] rd_warning_cnt_q, rd_warning_cnt_d;
    logic [1:0]           rd_flags_q, rd_flags_d;
    logic                 error_any_q, error_any_d;
    logic                 irq_q, irq_d;

    logic                 clr_ch_s;
    logic                 ev_err_s;
    logic                 ev_warn_s;
    logic                 irq_hit_s;

    // A clear and an event in the same cycle leave the count at one: the event is never lost.
    function automatic logic [CNT_WIDTH-1:0] next_cnt(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 evt,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] res;
        if (clr) begin
            res = evt ? CNT_ONE : CNT_ZERO;
        end else if (evt && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Next-state logic: live counters, shadow bank, read port, status outputs.
    always_comb begin
        clr_ch_s  = 1'b0;
        ev_err_s  = 1'b0;
        ev_warn_s = 1'b0;
        irq_hit_s = 1'b0;
        rd_ack_d  = rd_req;
        for (int i = 0; i < NB_CHANNELS; i++) begin
            clr_ch_s  = clr_all | (clr_sel & (rd_sel == SEL_WIDTH'(i)));
            ev_err_s  = enable & evt_error[i];
            ev_warn_s = enable & evt_warning[i];
            err_cnt_d[i]   = next_cnt(err_cnt_q[i], ev_err_s, clr_ch_s);
            warn_cnt_d[i]  = next_cnt(warn_cnt_q[i], ev_warn_s, clr_ch_s);
            err_flag_d[i]  = clr_ch_s ? ev_err_s  : (err_flag_q[i]  | ev_err_s);
            warn_flag_d[i] = clr_ch_s ? ev_warn_s : (warn_flag_q[i] | ev_warn_s);
        end

        // The snapshot sees this cycle's updates, and a same-cycle read sees the snapshot.
        for (int i = 0; i < NB_CHANNELS; i++) begin
            if (snapshot) begin
                sh_err_cnt_d[i]   = err_cnt_d[i];
                sh_warn_cnt_d[i]  = warn_cnt_d[i];
                sh_err_flag_d[i]  = err_flag_d[i];
                sh_warn_flag_d[i] = warn_flag_d[i];
            end else begin
                sh_err_cnt_d[i]   = sh_err_cnt_q[i];
                sh_warn_cnt_d[i]  = sh_warn_cnt_q[i];
                sh_err_flag_d[i]  = sh_err_flag_q[i];
                sh_warn_flag_d[i] = sh_warn_flag_q[i];
            end
        end

        if (rd_req) begin
            rd_error_cnt_d   = CNT_ZERO;
            rd_warning_cnt_d = CNT_ZERO;
            rd_flags_d       = 2'b00;
            for (int i = 0; i < NB_CHANNELS; i++) begin
                if (rd_sel == SEL_WIDTH'(i)) begin
                    rd_error_cnt_d   = sh_err_cnt_d[i];
                    rd_warning_cnt_d = sh_warn_cnt_d[i];
                    rd_flags_d       = {sh_err_flag_d[i], sh_warn_flag_d[i]};
                end else begin
                    rd_flags_d = rd_flags_d;
                end
            end
        end else begin
            rd_error_cnt_d   = rd_error_cnt_q;
            rd_warning_cnt_d = rd_warning_cnt_q;
            rd_flags_d       = rd_flags_q;
        end

        for (int i = 0; i < NB_CHANNELS; i++) begin
            if (!irq_mask[i] && (err_cnt_q[i] >= err_threshold)) begin
                irq_hit_s = 1'b1;
            end else begin
                irq_hit_s = irq_hit_s;
            end
        end
        irq_d       = (err_threshold != CNT_ZERO) && irq_hit_s;
        error_any_d = |err_flag_q;
    end

    // State registers with synchronous reset that overrides every input.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            for (int i = 0; i < NB_CHANNELS; i++) begin
                err_cnt_q[i]     <= CNT_ZERO;
                warn_cnt_q[i]    <= CNT_ZERO;
                sh_err_cnt_q[i]  <= CNT_ZERO;
                sh_warn_cnt_q[i] <= CNT_ZERO;
            end
            err_flag_q       <= {NB_CHANNELS{1'b0}};
            warn_flag_q      <= {NB_CHANNELS{1'b0}};
            sh_err_flag_q    <= {NB_CHANNELS{1'b0}};
            sh_warn_flag_q   <= {NB_CHANNELS{1'b0}};
            rd_ack_q         <= 1'b0;
            rd_error_cnt_q   <= CNT_ZERO;
            rd_warning_cnt_q <= CNT_ZERO;
            rd_flags_q       <= 2'b00;
            error_any_q      <= 1'b0;
            irq_q            <= 1'b0;
        end else begin
            for (int i = 0; i < NB_CHANNELS; i++) begin
                err_cnt_q[i]     <= err_cnt_d[i];
                warn_cnt_q[i]    <= warn_cnt_d[i];
                sh_err_cnt_q[i]  <= sh_err_cnt_d[i];
                sh_warn_cnt_q[i] <= sh_warn_cnt_d[i];
            end
            err_flag_q       <= err_flag_d;
            warn_flag_q      <= warn_flag_d;
            sh_err_flag_q    <= sh_err_flag_d;
            sh_warn_flag_q   <= sh_warn_flag_d;
            rd_ack_q         <= rd_ack_d;
            rd_error_cnt_q   <= rd_error_cnt_d;
            rd_warning_cnt_q <= rd_warning_cnt_d;
            rd_flags_q       <= rd_flags_d;
            error_any_q      <= error_any_d;
            irq_q            <= irq_d;
        end
    end

    assign rd_ack         = rd_ack_q;
    assign rd_error_cnt   = rd_error_cnt_q;
    assign rd_warning_cnt = rd_warning_cnt_q;
    assign rd_flags       = rd_flags_q;
    assign error_any      = error_any_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_xgs_status_collector.sv
// Directed bench: a default instance plus a 3-channel, 4-bit instance sharing the stimulus
// (saturation and out-of-range selector cases).
module tb_xgs_status_collector;
    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        enable;
    logic [3:0]  evt_error;
    logic [3:0]  evt_warning;
    logic [15:0] err_threshold;
    logic [3:0]  irq_mask;
    logic        snapshot;
    logic        clr_sel;
    logic        clr_all;
    logic        rd_req;
    logic [1:0]  rd_sel;

    logic        rd_ack;
    logic [15:0] rd_error_cnt;
    logic [15:0] rd_warning_cnt;
    logic [1:0]  rd_flags;
    logic        error_any;
    logic        irq;

    logic        s_rd_ack;
    logic [3:0]  s_rd_error_cnt;
    logic [3:0]  s_rd_warning_cnt;
    logic [1:0]  s_rd_flags;
    logic        s_error_any;
    logic        s_irq;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    xgs_status_collector #(.NB_CHANNELS(4), .CNT_WIDTH(16)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .enable(enable),
        .evt_error(evt_error), .evt_warning(evt_warning),
        .err_threshold(err_threshold), .irq_mask(irq_mask),
        .snapshot(snapshot), .clr_sel(clr_sel), .clr_all(clr_all),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack),
        .rd_error_cnt(rd_error_cnt), .rd_warning_cnt(rd_warning_cnt),
        .rd_flags(rd_flags), .error_any(error_any), .irq(irq)
    );

    xgs_status_collector #(.NB_CHANNELS(3), .CNT_WIDTH(4)) dut_small (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .enable(enable),
        .evt_error(evt_error[2:0]), .evt_warning(evt_warning[2:0]),
        .err_threshold(4'd0), .irq_mask(irq_mask[2:0]),
        .snapshot(snapshot), .clr_sel(clr_sel), .clr_all(clr_all),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(s_rd_ack),
        .rd_error_cnt(s_rd_error_cnt), .rd_warning_cnt(s_rd_warning_cnt),
        .rd_flags(s_rd_flags), .error_any(s_error_any), .irq(s_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic pulse_err(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            evt_error = 4'b0001 << ch;
            step();
        end
        evt_error = 4'b0000;
    endtask

    task automatic pulse_warn(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            evt_warning = 4'b0001 << ch;
            step();
        end
        evt_warning = 4'b0000;
    endtask

    task automatic snap();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
    endtask

    task automatic clear_all();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
    endtask

    // One-cycle request; returns at the sample point where ack and data must be valid.
    task automatic issue_read(input logic [1:0] sel, input logic snap_too);
        rd_sel   = sel;
        rd_req   = 1'b1;
        snapshot = snap_too;
        step();
        rd_req   = 1'b0;
        snapshot = 1'b0;
        check_eq("rd_ack", 32'(rd_ack), 32'd1);
    endtask

    initial begin
        sys_reset     = 1'b1;
        enable        = 1'b1;
        evt_error     = 4'b0000;
        evt_warning   = 4'b0000;
        err_threshold = 16'd0;
        irq_mask      = 4'b0000;
        snapshot      = 1'b0;
        clr_sel       = 1'b0;
        clr_all       = 1'b0;
        rd_req        = 1'b0;
        rd_sel        = 2'd0;
        step();
        step();
        check_eq("reset_rd_ack", 32'(rd_ack), 32'd0);
        check_eq("reset_rd_err", 32'(rd_error_cnt), 32'd0);
        check_eq("reset_rd_warn", 32'(rd_warning_cnt), 32'd0);
        check_eq("reset_rd_flags", 32'(rd_flags), 32'd0);
        check_eq("reset_error_any", 32'(error_any), 32'd0);
        check_eq("reset_irq", 32'(irq), 32'd0);
        sys_reset = 1'b0;
        step();

        // Basic counting, snapshot and read handshake
        pulse_err(2, 5);
        pulse_warn(0, 3);
        snap();
        issue_read(2'd2, 1'b0);
        check_eq("ch2_err", 32'(rd_error_cnt), 32'd5);
        check_eq("ch2_warn", 32'(rd_warning_cnt), 32'd0);
        check_eq("ch2_flags", 32'(rd_flags), 32'b10);
        step();
        check_eq("rd_ack_one_cycle", 32'(rd_ack), 32'd0);
        check_eq("rd_data_held", 32'(rd_error_cnt), 32'd5);
        issue_read(2'd0, 1'b0);
        check_eq("ch0_err", 32'(rd_error_cnt), 32'd0);
        check_eq("ch0_warn", 32'(rd_warning_cnt), 32'd3);
        check_eq("ch0_flags", 32'(rd_flags), 32'b01);
        check_eq("error_any_set", 32'(error_any), 32'd1);

        // Saturation on the 4-bit instance, disabled counting, out-of-range selector
        clear_all();
        pulse_err(1, 20);
        enable = 1'b0;
        pulse_err(1, 1);
        enable = 1'b1;
        rd_sel  = 2'd3;
        clr_sel = 1'b1;
        step();
        clr_sel = 1'b0;
        snap();
        issue_read(2'd1, 1'b0);
        check_eq("wide_ch1_err", 32'(rd_error_cnt), 32'd20);
        check_eq("sat_ack", 32'(s_rd_ack), 32'd1);
        check_eq("sat_ch1_err", 32'(s_rd_error_cnt), 32'd15);
        check_eq("sat_ch1_flags", 32'(s_rd_flags), 32'b10);
        issue_read(2'd3, 1'b0);
        check_eq("oor_ack", 32'(s_rd_ack), 32'd1);
        check_eq("oor_err", 32'(s_rd_error_cnt), 32'd0);
        check_eq("oor_flags", 32'(s_rd_flags), 32'd0);

        // Threshold interrupt, masking, threshold change and clear
        clear_all();
        err_threshold = 16'd3;
        pulse_err(3, 3);
        check_eq("irq_latency_1", 32'(irq), 32'd0);
        step();
        check_eq("irq_latency_2", 32'(irq), 32'd1);
        irq_mask = 4'b1000;
        step();
        check_eq("irq_masked", 32'(irq), 32'd0);
        check_eq("error_any_masked", 32'(error_any), 32'd1);
        irq_mask      = 4'b0000;
        err_threshold = 16'd4;
        step();
        check_eq("irq_thr4", 32'(irq), 32'd0);
        err_threshold = 16'd0;
        step();
        check_eq("irq_thr0", 32'(irq), 32'd0);
        err_threshold = 16'd3;
        step();
        check_eq("irq_rearm", 32'(irq), 32'd1);
        rd_sel  = 2'd3;
        clr_sel = 1'b1;
        step();
        clr_sel = 1'b0;
        step();
        check_eq("irq_after_clr", 32'(irq), 32'd0);
        err_threshold = 16'd0;

        // Same-cycle event and selective clear
        clear_all();
        pulse_err(1, 7);
        evt_error = 4'b0010;
        rd_sel    = 2'd1;
        clr_sel   = 1'b1;
        step();
        evt_error = 4'b0000;
        clr_sel   = 1'b0;
        snap();
        issue_read(2'd1, 1'b0);
        check_eq("clr_evt_err", 32'(rd_error_cnt), 32'd1);
        check_eq("clr_evt_flags", 32'(rd_flags), 32'b10);

        // Shadow bank holds until the next snapshot
        clear_all();
        pulse_err(0, 2);
        snap();
        pulse_err(0, 4);
        issue_read(2'd0, 1'b0);
        check_eq("shadow_old", 32'(rd_error_cnt), 32'd2);
        issue_read(2'd0, 1'b1);
        check_eq("shadow_new", 32'(rd_error_cnt), 32'd6);

        // Reset mid-operation drops the pending ack
        rd_sel    = 2'd0;
        rd_req    = 1'b1;
        sys_reset = 1'b1;
        step();
        rd_req    = 1'b0;
        sys_reset = 1'b0;
        check_eq("rst_rd_ack", 32'(rd_ack), 32'd0);
        check_eq("rst_rd_err", 32'(rd_error_cnt), 32'd0);
        check_eq("rst_error_any", 32'(error_any), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        issue_read(2'd0, 1'b1);
        check_eq("rst_live_err", 32'(rd_error_cnt), 32'd0);
        check_eq("rst_live_flags", 32'(rd_flags), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
